debounce_scheduler: RTL and testbench
=====================================

DEBOUNCE_SCHEDULER -- requirements
Module: debounce_scheduler

Interface
REQ-001 Parameter N_CH, default 4: number of switch channels, 2..8.
REQ-002 Parameter TICK_DIV, default 25000: clock cycles per sample tick (1 ms at 25 MHz), at least 2.
REQ-003 Parameter STABLE_TICKS, default 10: consecutive differing ticks required to commit a change, 1..255.
REQ-004 i_Clk  input  1  sole clock, all state on rising edge.
REQ-005 i_Rst  input  1  reset, asynchronous, active-high.
REQ-006 i_Switch  input  N_CH  raw asynchronous switch levels.
REQ-007 o_State  output  N_CH  debounced level per channel.
REQ-008 o_Evt_Valid  output  1  event presented.
REQ-009 i_Evt_Ready  input  1  consumer accepts event.
REQ-010 o_Evt_Ch  output  clog2(N_CH)  channel index of presented event.
REQ-011 o_Evt_Press  output  1  1 = 0->1 transition, 0 = 1->0 transition.
REQ-012 o_Overflow  output  N_CH  sticky flag per channel: an unconsumed event was overwritten.
REQ-013 i_Ovf_Clr  input  1  clears all o_Overflow bits.

Function
REQ-014 Each i_Switch bit SHALL pass a 2-flop synchronizer before any use.
REQ-015 One shared prescaler SHALL count 0..TICK_DIV-1 and wrap, pulsing tick for one cycle at count TICK_DIV-1.
REQ-016 On tick, per channel: if sync != o_State, the counter increments; if sync == o_State, the counter clears. Between ticks counters hold.
REQ-017 When the incremented value equals STABLE_TICKS, o_State SHALL take sync, the counter SHALL clear, and pend[ch] SHALL set with dir[ch] = new level, all in the same edge.
REQ-018 A glitch returning to o_State before STABLE_TICKS ticks SHALL produce no state change and no event.
REQ-019 Arbiter FSM states IDLE and PRESENT. IDLE: if any pend is set, grant the first set channel in round-robin order starting at last_grant+1 (mod N_CH), load o_Evt_Ch/o_Evt_Press, clear that pend, assert o_Evt_Valid, go PRESENT. IDLE with no pend: o_Evt_Valid = 0.
REQ-020 PRESENT: o_Evt_Valid, o_Evt_Ch and o_Evt_Press SHALL hold stable until o_Evt_Valid & i_Evt_Ready. On that edge: deassert, update last_grant, go IDLE.
REQ-021 Latency: a commit at edge T SHALL give o_Evt_Valid = 1 at edge T+1 when the FSM is IDLE. Peak throughput: one event per 2 cycles.
REQ-022 Commit on a channel whose pend is already set SHALL overwrite dir and set o_Overflow[ch].
REQ-023 Commit and grant-clear on the same channel in the same cycle: set wins; pend remains set with the new dir, and no overflow is flagged.
REQ-024 i_Ovf_Clr and an overflow set in the same cycle: set wins.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 While i_Rst is high: prescaler, channel counters, synchronizers, o_State, pend, dir, o_Overflow, o_Evt_Ch, o_Evt_Press and o_Evt_Valid SHALL be 0, FSM SHALL be IDLE, and last_grant SHALL be N_CH-1, so that channel 0 is first.
REQ-027 Reset asserted in PRESENT SHALL drop o_Evt_Valid asynchronously and discard the presented and pending events.

Structure
REQ-028 Shared package debounce_pkg SHALL hold the default N_CH, TICK_DIV and STABLE_TICKS, and the FSM state enum (IDLE, PRESENT).
REQ-029 Sub-module debounce_channel (synchronizer, counter, state, commit pulse, new level) SHALL be instantiated N_CH times. The prescaler and arbiter SHALL reside in the top.

Verification (TICK_DIV=4, STABLE_TICKS=3, N_CH=4)
REQ-030 Raise i_Switch[0] and hold 20 cycles -> o_State[0]=1 on the 3rd tick after sync, one event with Ch=0 and Press=1, Valid the next cycle.
REQ-031 Pulse i_Switch[1] high for 2 ticks then low -> o_State[1] stays 0 and no event occurs.
REQ-032 Commit channels 2 and 0 on the same edge with i_Evt_Ready=1 -> events presented in order Ch=0 then Ch=2, each Valid for 1 cycle, 1 idle cycle between.
REQ-033 i_Evt_Ready=0, ch3 press then release committed -> one event Ch=3 with Press=0, o_Overflow[3]=1; i_Ovf_Clr pulse -> o_Overflow=0.
REQ-034 Assert i_Rst mid-PRESENT with Valid=1 -> o_Evt_Valid=0 immediately, o_State=0, and no event after release until a new commit.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared defaults and arbiter state type for the debounce scheduler.
package debounce_pkg;

  localparam int unsigned N_CH_DEF         = 4;
  localparam int unsigned TICK_DIV_DEF     = 25000;
  localparam int unsigned STABLE_TICKS_DEF = 10;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: 2-flop synchronizer, tick-based stability counter and
// debounced level; flags a commit combinationally on the committing tick.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Switch,
  input  logic i_Tick,
  output logic o_State,
  output logic o_Commit_c,
  output logic o_Level_c
);

  localparam int unsigned CNT_W = 8;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter only moves on ticks; any tick agreeing with the state restarts it.
  always_comb begin
    sync1_d    = i_Switch;
    sync2_d    = sync1_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    o_Commit_c = 1'b0;
    if (i_Tick) begin
      if (sync2_q != state_q) begin
        if (cnt_inc == CNT_W'(STABLE_TICKS)) begin
          state_d    = sync2_q;
          cnt_d      = '0;
          o_Commit_c = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  assign o_State   = state_q;
  assign o_Level_c = sync2_q;

endmodule

// File: rtl/debounce_scheduler.sv
// Multi-channel switch debouncer with a shared sample prescaler and a
// round-robin valid/ready event arbiter with per-channel overflow flags.
module debounce_scheduler
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH         = N_CH_DEF,
  parameter int unsigned TICK_DIV     = TICK_DIV_DEF,
  parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic [N_CH-1:0]         i_Switch,
  output logic [N_CH-1:0]         o_State,
  output logic                    o_Evt_Valid,
  input  logic                    i_Evt_Ready,
  output logic [$clog2(N_CH)-1:0] o_Evt_Ch,
  output logic                    o_Evt_Press,
  output logic [N_CH-1:0]         o_Overflow,
  input  logic                    i_Ovf_Clr
);

  localparam int unsigned CH_W  = $clog2(N_CH);
  localparam int unsigned PRE_W = $clog2(TICK_DIV);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick_c;
  logic [N_CH-1:0]  commit_c, level_c;

  arb_state_e       state_q, state_d;
  logic [N_CH-1:0]  pend_q, pend_d;
  logic [N_CH-1:0]  dir_q, dir_d;
  logic [N_CH-1:0]  ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic             press_q, press_d;
  logic [CH_W-1:0]  last_q, last_d;
  logic             gnt_vld_c;
  logic [CH_W-1:0]  gnt_c, cand_c;

  assign tick_c = (pre_q == PRE_W'(TICK_DIV - 1));

  always_comb begin
    pre_d = tick_c ? '0 : pre_q + PRE_W'(1);
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_ch (
      .i_Clk      (i_Clk),
      .i_Rst      (i_Rst),
      .i_Switch   (i_Switch[g]),
      .i_Tick     (tick_c),
      .o_State    (o_State[g]),
      .o_Commit_c (commit_c[g]),
      .o_Level_c  (level_c[g])
    );
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      pre_q   <= '0;
      state_q <= IDLE;
      pend_q  <= '0;
      dir_q   <= '0;
      ovf_q   <= '0;
      valid_q <= 1'b0;
      ch_q    <= '0;
      press_q <= 1'b0;
      last_q  <= CH_W'(N_CH - 1);
    end else begin
      pre_q   <= pre_d;
      state_q <= state_d;
      pend_q  <= pend_d;
      dir_q   <= dir_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      ch_q    <= ch_d;
      press_q <= press_d;
      last_q  <= last_d;
    end
  end

  // Round-robin search starting just after the last accepted channel.
  always_comb begin
    gnt_vld_c = 1'b0;
    gnt_c     = '0;
    cand_c    = '0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      cand_c = CH_W'((32'(last_q) + k) % N_CH);
      if (!gnt_vld_c && pend_q[cand_c]) begin
        gnt_vld_c = 1'b1;
        gnt_c     = cand_c;
      end
    end
  end

  // Grant clears pend before commits are applied, so a same-cycle commit wins
  // and only a still-pending slot counts as overwritten.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    dir_d   = dir_q;
    ovf_d   = i_Ovf_Clr ? '0 : ovf_q;
    valid_d = valid_q;
    ch_d    = ch_q;
    press_d = press_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld_c) begin
          state_d        = PRESENT;
          valid_d        = 1'b1;
          ch_d           = gnt_c;
          press_d        = dir_q[gnt_c];
          pend_d[gnt_c]  = 1'b0;
        end
      end
      PRESENT: begin
        if (valid_q && i_Evt_Ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          last_d  = ch_q;
        end
      end
      default: state_d = IDLE;
    endcase
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (commit_c[c]) begin
        if (pend_d[c]) ovf_d[c] = 1'b1;
        pend_d[c] = 1'b1;
        dir_d[c]  = level_c[c];
      end
    end
  end

  assign o_Evt_Valid = valid_q;
  assign o_Evt_Ch    = ch_q;
  assign o_Evt_Press = press_q;
  assign o_Overflow  = ovf_q;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Bench for debounce_scheduler: directed scenarios plus a randomized run
// compared every cycle against a behavioural reference model.
module tb_debounce_scheduler;

  localparam int N_CH     = 4;
  localparam int TICK_DIV = 4;
  localparam int STABLE   = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic       rdy;
  logic       clr;
  logic [3:0] state;
  logic       valid;
  logic [1:0] ch;
  logic       press;
  logic [3:0] ovf;

  int unsigned n_pass;
  int unsigned n_total;

  debounce_scheduler #(
    .N_CH         (N_CH),
    .TICK_DIV     (TICK_DIV),
    .STABLE_TICKS (STABLE)
  ) dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .i_Switch    (sw),
    .o_State     (state),
    .o_Evt_Valid (valid),
    .i_Evt_Ready (rdy),
    .o_Evt_Ch    (ch),
    .o_Evt_Press (press),
    .o_Overflow  (ovf),
    .i_Ovf_Clr   (clr)
  );

  always #5 clk = ~clk;

  // Reference model: sample ticks are every TICK_DIV-th cycle since reset,
  // the input is seen two cycles late, and each channel keeps one event slot.
  int       m_edge;
  logic [3:0] m_s1, m_s2, m_st, m_pend, m_dir, m_ovf;
  int       m_run [N_CH];
  logic     m_valid, m_press;
  int       m_ch, m_last;
  int       m_gnt;
  logic     m_tick;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_edge = 0;
        m_s1 = '0; m_s2 = '0; m_st = '0; m_pend = '0; m_dir = '0; m_ovf = '0;
        for (int c = 0; c < N_CH; c++) m_run[c] = 0;
        m_valid = 1'b0; m_press = 1'b0; m_ch = 0; m_last = N_CH - 1;
      end else begin
        m_tick = ((m_edge % TICK_DIV) == TICK_DIV - 1);
        m_edge++;
        m_gnt = -1;
        if (!m_valid) begin
          for (int k = 1; k <= N_CH; k++)
            if (m_gnt < 0 && m_pend[(m_last + k) % N_CH]) m_gnt = (m_last + k) % N_CH;
        end else if (rdy) begin
          m_valid = 1'b0;
          m_last  = m_ch;
        end
        if (clr) m_ovf = '0;
        if (m_gnt >= 0) begin
          m_valid = 1'b1;
          m_ch    = m_gnt;
          m_press = m_dir[m_gnt];
          m_pend[m_gnt] = 1'b0;
        end
        for (int c = 0; c < N_CH; c++) begin
          if (m_tick) begin
            if (m_s2[c] != m_st[c]) begin
              m_run[c]++;
              if (m_run[c] == STABLE) begin
                m_st[c]  = m_s2[c];
                m_run[c] = 0;
                if (m_pend[c]) m_ovf[c] = 1'b1;
                m_pend[c] = 1'b1;
                m_dir[c]  = m_s2[c];
              end
            end else begin
              m_run[c] = 0;
            end
          end
        end
        m_s2 = m_s1;
        m_s1 = sw;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; sw = '0; rdy = 1'b0; clr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; sw = 4'b1011; rdy = 1'b1; clr = 1'b0;
    repeat (3) @(negedge clk);
    n_total++; if (state !== 4'b0) $display("FAIL reset_state: got %b expected 0000", state); else n_pass++;
    n_total++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid); else n_pass++;
    n_total++; if (ch !== 2'd0) $display("FAIL reset_ch: got %0d expected 0", ch); else n_pass++;
    n_total++; if (press !== 1'b0) $display("FAIL reset_press: got %b expected 0", press); else n_pass++;
    n_total++; if (ovf !== 4'b0) $display("FAIL reset_ovf: got %b expected 0000", ovf); else n_pass++;
  endtask

  task automatic test_press();
    int st_cyc = -1, v_cyc = -1, nev = 0, bad = 0;
    do_reset();
    rdy = 1'b1; sw[0] = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (state[0] === 1'b1 && st_cyc < 0) st_cyc = i;
      if (valid === 1'b1) begin
        nev++;
        if (v_cyc < 0) v_cyc = i;
        if (ch !== 2'd0 || press !== 1'b1) bad++;
      end
    end
    n_total++; if (st_cyc != 12) $display("FAIL press_commit_cycle: got %0d expected 12", st_cyc); else n_pass++;
    n_total++; if (v_cyc != 13) $display("FAIL press_valid_cycle: got %0d expected 13", v_cyc); else n_pass++;
    n_total++; if (nev != 1) $display("FAIL press_event_count: got %0d expected 1", nev); else n_pass++;
    n_total++; if (bad != 0) $display("FAIL press_event_fields: got %0d bad expected 0", bad); else n_pass++;
    n_total++; if (state !== 4'b0001) $display("FAIL press_final_state: got %b expected 0001", state); else n_pass++;
  endtask

  task automatic test_glitch();
    logic seen_st = 1'b0, seen_v = 1'b0;
    do_reset();
    rdy = 1'b1; sw[1] = 1'b1;
    for (int i = 1; i <= 48; i++) begin
      @(negedge clk);
      seen_st |= state[1];
      seen_v  |= valid;
      if (i == 8) sw[1] = 1'b0;
    end
    n_total++; if (seen_st !== 1'b0) $display("FAIL glitch_state: got %b expected 0", seen_st); else n_pass++;
    n_total++; if (seen_v !== 1'b0) $display("FAIL glitch_event: got %b expected 0", seen_v); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int ev_ch [4] = '{-1, -1, -1, -1};
    int ev_cyc [4] = '{-1, -1, -1, -1};
    int ev_pr [4] = '{-1, -1, -1, -1};
    do_reset();
    rdy = 1'b1; sw = 4'b0101;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        if (n < 4) begin ev_ch[n] = int'(ch); ev_cyc[n] = i; ev_pr[n] = int'(press); end
        n++;
      end
    end
    n_total++; if (n != 2) $display("FAIL b2b_count: got %0d expected 2", n); else n_pass++;
    n_total++; if (ev_ch[0] != 0) $display("FAIL b2b_first_ch: got %0d expected 0", ev_ch[0]); else n_pass++;
    n_total++; if (ev_ch[1] != 2) $display("FAIL b2b_second_ch: got %0d expected 2", ev_ch[1]); else n_pass++;
    n_total++; if (ev_cyc[0] != 13) $display("FAIL b2b_first_cycle: got %0d expected 13", ev_cyc[0]); else n_pass++;
    n_total++; if (ev_cyc[1] - ev_cyc[0] != 2) $display("FAIL b2b_spacing: got %0d expected 2", ev_cyc[1] - ev_cyc[0]); else n_pass++;
    n_total++; if (ev_pr[0] != 1 || ev_pr[1] != 1) $display("FAIL b2b_press: got %0d,%0d expected 1,1", ev_pr[0], ev_pr[1]); else n_pass++;
  endtask

  task automatic test_overflow();
    int hold_bad = 0, n3 = 0, n0 = 0, p3 = -1;
    do_reset();
    rdy = 1'b0; sw = 4'b1001;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i >= 13 && (valid !== 1'b1 || ch !== 2'd0 || press !== 1'b1)) hold_bad++;
      if (i == 12) sw[3] = 1'b0;
    end
    n_total++; if (hold_bad != 0) $display("FAIL ovf_hold_stable: got %0d bad cycles expected 0", hold_bad); else n_pass++;
    n_total++; if (ovf !== 4'b1000) $display("FAIL ovf_set: got %b expected 1000", ovf); else n_pass++;
    n_total++; if (state !== 4'b0001) $display("FAIL ovf_state: got %b expected 0001", state); else n_pass++;
    rdy = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (valid === 1'b1 && ch === 2'd3) begin n3++; p3 = int'(press); end
      if (valid === 1'b1 && ch === 2'd0) n0++;
    end
    n_total++; if (n3 != 1) $display("FAIL ovf_ch3_count: got %0d expected 1", n3); else n_pass++;
    n_total++; if (p3 != 0) $display("FAIL ovf_ch3_press: got %0d expected 0", p3); else n_pass++;
    n_total++; if (n0 != 0) $display("FAIL ovf_ch0_repeat: got %0d expected 0", n0); else n_pass++;
    n_total++; if (ovf !== 4'b1000) $display("FAIL ovf_sticky: got %b expected 1000", ovf); else n_pass++;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_total++; if (ovf !== 4'b0000) $display("FAIL ovf_clear: got %b expected 0000", ovf); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic seen_v = 1'b0;
    do_reset();
    rdy = 1'b0; sw = 4'b0001;
    repeat (13) @(negedge clk);
    n_total++; if (valid !== 1'b1) $display("FAIL rstmid_pre_valid: got %b expected 1", valid); else n_pass++;
    #2 rst = 1'b1; sw = '0;
    #1;
    n_total++; if (valid !== 1'b0) $display("FAIL rstmid_async_valid: got %b expected 0", valid); else n_pass++;
    n_total++; if (state !== 4'b0) $display("FAIL rstmid_state: got %b expected 0000", state); else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0; rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen_v |= valid;
    end
    n_total++; if (seen_v !== 1'b0) $display("FAIL rstmid_no_event: got %b expected 0", seen_v); else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      n_total++; if (state !== m_st) $display("FAIL rnd_state cyc %0d: got %b expected %b", i, state, m_st); else n_pass++;
      n_total++; if (valid !== m_valid) $display("FAIL rnd_valid cyc %0d: got %b expected %b", i, valid, m_valid); else n_pass++;
      if (m_valid) begin
        n_total++; if (ch !== 2'(m_ch)) $display("FAIL rnd_ch cyc %0d: got %0d expected %0d", i, ch, m_ch); else n_pass++;
        n_total++; if (press !== m_press) $display("FAIL rnd_press cyc %0d: got %b expected %b", i, press, m_press); else n_pass++;
      end
      n_total++; if (ovf !== m_ovf) $display("FAIL rnd_ovf cyc %0d: got %b expected %b", i, ovf, m_ovf); else n_pass++;
      for (int c = 0; c < N_CH; c++)
        if ($urandom_range(0, 39) == 0) sw[c] = ~sw[c];
      rdy = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 49) == 0);
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1; sw = '0; rdy = 1'b0; clr = 1'b0;
    test_reset();
    test_press();
    test_glitch();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
